// File: rtl/color_cmd_pkg.sv
// Shared types for the Color FSM command path: command encoding and generator states.
package color_cmd_pkg;

    typedef enum logic [1:0] {
        CmdHold   = 2'h0,
        CmdToggle = 2'h1
    } Cmd_t;

    typedef enum logic [2:0] {
        Idle,
        Debounce,
        Fire,
        Held,
        Release
    } CmdGen_state;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/color_btn_sync.sv
// Two-flop synchronizer for the raw push-button level, cleared by synchronous reset.
module color_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/color_cmd_gen.sv
// Debounced push-button to one-cycle toggle command generator with optional auto-repeat.
// Define COLOR_CMD_SYNC_EN to insert a 2-flop synchronizer on btn.
module color_cmd_gen
    import color_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 8,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               btn,
    output logic [1:0]         cmd,
    output logic [COUNT_W-1:0] toggle_count
);

    localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam bit REPEAT_ON = (REPEAT_CYCLES != 0);

    logic btn_s;

`ifdef COLOR_CMD_SYNC_EN
    color_btn_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );
`else
    assign btn_s = btn;
`endif

    CmdGen_state       state, state_nxt;
    logic [CNT_W-1:0]  timer, timer_nxt;
    logic [COUNT_W-1:0] count_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= Idle;
            timer        <= '0;
            toggle_count <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            toggle_count <= count_nxt;
        end
    end

    // Next-state: enable low parks the FSM; Fire is a single-cycle pulse state.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        count_nxt = toggle_count;
        if (!enable) begin
            state_nxt = Idle;
            timer_nxt = '0;
        end else begin
            case (state)
                Idle: begin
                    if (btn_s) begin
                        state_nxt = Debounce;
                        timer_nxt = '0;
                    end
                end
                Debounce: begin
                    if (!btn_s) begin
                        state_nxt = Idle;
                        timer_nxt = '0;
                    end else if (timer == DEB_LAST) begin
                        state_nxt = Fire;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
                Fire: begin
                    count_nxt = toggle_count + COUNT_W'(1);
                    state_nxt = Held;
                    timer_nxt = '0;
                end
                Held: begin
                    if (!btn_s) begin
                        state_nxt = Release;
                        timer_nxt = '0;
                    end else if (REPEAT_ON && (timer == REP_LAST)) begin
                        state_nxt = Fire;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
                Release: begin
                    // A high sample here is release bounce: rejoin Held without a new toggle.
                    if (btn_s) begin
                        state_nxt = Held;
                        timer_nxt = '0;
                    end else if (timer == DEB_LAST) begin
                        state_nxt = Idle;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = Idle;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Decoded from the state register only; enable masks a coinciding Fire cycle.
    assign cmd = ((state == Fire) && enable) ? CmdToggle : CmdHold;

endmodule

// File: tb/tb_color_cmd_gen.sv
// Scoreboard bench for color_cmd_gen: two parameterisations driven by one stimulus stream
// and checked against a run-length model of the debounce/repeat rules.
module tb_color_cmd_gen;

    localparam int D0 = 4;
    localparam int R0 = 8;
    localparam int W0 = 8;
    localparam int D1 = 1;
    localparam int R1 = 0;
    localparam int W1 = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          btn = 1'b0;
    logic [1:0]    cmd0, cmd1;
    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    // Model: debounced level plus consecutive-sample run lengths.
    typedef struct {
        bit pressed;
        int hi;
        int lo;
        int hold;
        bit fire;
        int cnt;
        bit s1;
        bit s2;
    } mdl_t;

    typedef struct {
        bit cmd;
        int cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    mdl_t m0, m1;

    always #5 clk = ~clk;

    color_cmd_gen #(.DEBOUNCE_CYCLES(D0), .REPEAT_CYCLES(R0), .COUNT_W(W0)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .btn(btn), .cmd(cmd0), .toggle_count(cnt0)
    );

    color_cmd_gen #(.DEBOUNCE_CYCLES(D1), .REPEAT_CYCLES(R1), .COUNT_W(W1)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .btn(btn), .cmd(cmd1), .toggle_count(cnt1)
    );

    // A press fires on the (d+1)th consecutive high sample; a release needs d+1 lows;
    // while pressed, every r-th consecutive high sample fires again; the sample right
    // after a fire is the pulse cycle itself and is not looked at.
    function automatic mdl_t mdl_step(input mdl_t m, input int d, input int r, input int w,
                                      input bit rs, input bit en, input bit b);
        mdl_t n;
        bit   be;
        n = m;
`ifdef COLOR_CMD_SYNC_EN
        be   = m.s2;
        n.s2 = m.s1;
        n.s1 = b;
`else
        be = b;
`endif
        if (rs) begin
            n = '{default: 0};
            return n;
        end
        if (!en) begin
            n.pressed = 0; n.hi = 0; n.lo = 0; n.hold = 0; n.fire = 0;
            return n;
        end
        if (m.fire) begin
            n.fire = 0;
            n.cnt = (m.cnt + 1) % (1 << w);
            n.pressed = 1; n.hold = 0; n.lo = 0;
        end else if (!m.pressed) begin
            if (be) begin
                n.hi = m.hi + 1;
                if (n.hi == d + 1) begin
                    n.fire = 1;
                    n.hi = 0;
                end
            end else begin
                n.hi = 0;
            end
        end else if (be) begin
            if (m.lo > 0) begin
                n.lo = 0;
                n.hold = 0;
            end else begin
                n.hold = m.hold + 1;
                if (r != 0 && n.hold == r) begin
                    n.fire = 1;
                    n.hold = 0;
                end
            end
        end else begin
            n.lo = m.lo + 1;
            n.hold = 0;
            if (n.lo == d + 1) begin
                n.pressed = 0; n.lo = 0; n.hi = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Apply inputs for one cycle, queue the expected outputs for that cycle, advance model.
    task automatic step(input bit r, input bit e, input bit b);
        rst = r;
        enable = e;
        btn = b;
        q0.push_back('{cmd: m0.fire && e, cnt: m0.cnt});
        q1.push_back('{cmd: m1.fire && e, cnt: m1.cnt});
        @(posedge clk);
        m0 = mdl_step(m0, D0, R0, W0, r, e, b);
        m1 = mdl_step(m1, D1, R1, W1, r, e, b);
        #1;
    endtask

    task automatic run(input bit r, input bit e, input bit b, input int n);
        for (int i = 0; i < n; i++) step(r, e, b);
    endtask

    // Monitor: every cycle both DUTs present cmd/toggle_count; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cmd0 === 2'd1) pulses0++;
            if (cmd1 === 2'd1) pulses1++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("u0_cmd", 32'(cmd0), 32'(e.cmd));
                chk("u0_count", 32'(cnt0), 32'(e.cnt));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("u1_cmd", 32'(cmd1), 32'(e.cmd));
                chk("u1_count", 32'(cnt1), 32'(e.cnt));
            end
        end
    end

    initial begin
        int p0, p1;
        bit lvl;
        int len;

        @(posedge clk);
        m0 = '{default: 0};
        m1 = '{default: 0};
        #1;
        run(1, 1, 0, 2);
        chk("reset_count0", 32'(cnt0), 0);
        chk("reset_cmd0", 32'(cmd0), 0);

        // Single clean press
        run(0, 1, 0, 5);
        run(0, 1, 1, 6);
        run(0, 1, 0, 8);
        chk("press_count0", 32'(cnt0), 1);
        chk("press_count1", 32'(cnt1), 1);

        // Press bounce
        p0 = pulses0;
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 0);
        run(0, 1, 1, 6);
        run(0, 1, 0, 8);
        chk("bounce_pulses0", 32'(pulses0 - p0), 1);

        // Auto-repeat over a 40-cycle hold
        p0 = pulses0;
        p1 = pulses1;
        run(0, 1, 1, 40);
        run(0, 1, 0, 8);
        chk("repeat_pulses0", 32'(pulses0 - p0), 4);
        chk("repeat_pulses1", 32'(pulses1 - p1), 1);

        // Release bounce
        p0 = pulses0;
        run(0, 1, 1, 6);
        step(0, 1, 0); step(0, 1, 1);
        run(0, 1, 0, 8);
        chk("relbounce_pulses0", 32'(pulses0 - p0), 1);

        // enable dropped exactly on u0's pulse cycle
        p0 = pulses0;
        run(0, 1, 1, 5);
        step(0, 0, 1);
        run(0, 1, 1, 3);
        run(0, 1, 0, 8);
        chk("enable_mask_pulses0", 32'(pulses0 - p0), 0);

        // Reset mid-Held with the button still down
        run(0, 1, 1, 8);
        run(1, 1, 1, 2);
        chk("midreset_count0", 32'(cnt0), 0);
        run(0, 1, 1, 6);
        run(0, 1, 0, 8);
        chk("postreset_count0", 32'(cnt0), 1);

        // Randomized bouncy button with occasional enable drops and resets
        lvl = 1'b0;
        len = 0;
        for (int i = 0; i < 1500; i++) begin
            if (len == 0) begin
                lvl = !lvl;
                len = int'($urandom_range(1, 14));
            end
            len--;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0, lvl);
        end

        // 256 clean presses wrap both counters back to zero
        run(1, 1, 0, 2);
        run(0, 1, 0, 2);
        for (int i = 0; i < 256; i++) begin
            run(0, 1, 1, 6);
            run(0, 1, 0, 6);
        end
        chk("wrap_count0", 32'(cnt0), 0);
        chk("wrap_count1", 32'(cnt1), 0);

        run(0, 1, 0, 2);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q0.size() + q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
